// File: rtl/store_data_demux.sv
// Routes one request stream to port A (data memory) or port B (peripheral bridge) by address.
// Define DEMUX_UNMAPPED_ERR_EN to reject unmapped addresses with a timeout_err pulse instead of sending them to port A.
module store_data_demux #(
  parameter logic [31:0] A_LIMIT = 32'h0000_3000,
  parameter logic [31:0] B_BASE  = 32'h0000_7F00,
  parameter logic [31:0] B_TOP   = 32'h0000_7F1F,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_we,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_addr,
  output logic [31:0] a_wdata,
  output logic        a_we,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [31:0] b_addr,
  output logic [31:0] b_wdata,
  output logic        b_we,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        r_terr;
  logic [31:0] r_a_addr, r_a_wdata, r_b_addr, r_b_wdata;
  logic        r_a_we, r_b_we;

  logic w_is_a, w_is_b, w_route_a, w_accept, w_sending, w_rdy, w_last, w_abandon, w_reject;

  assign w_is_a    = (in_addr < A_LIMIT);
  assign w_is_b    = !w_is_a && (in_addr >= B_BASE) && (in_addr <= B_TOP);
`ifdef DEMUX_UNMAPPED_ERR_EN
  assign w_route_a = w_is_a;
`else
  assign w_route_a = !w_is_b;
`endif
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_reject  = w_accept && !w_route_a && !w_is_b;
  assign w_sending = (r_state == SEND_A) || (r_state == SEND_B);
  assign w_rdy     = (r_state == SEND_A) ? a_ready : b_ready;
  assign w_last    = (r_wait == LP_LAST);
  assign w_abandon = w_sending && !w_rdy && w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_route_a)   w_next = SEND_A;
          else if (w_is_b) w_next = SEND_B;
        end
      end
      SEND_A, SEND_B: begin
        if (w_rdy || w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
    a_valid  = (r_state == SEND_A);
    b_valid  = (r_state == SEND_B);
  end

  // Each port keeps its own payload so an idle port holds its last request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait    <= '0;
      r_terr    <= 1'b0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
      r_a_we    <= 1'b0;
      r_b_addr  <= '0;
      r_b_wdata <= '0;
      r_b_we    <= 1'b0;
    end else begin
      r_terr <= w_abandon || w_reject;
      if (w_accept) begin
        r_wait <= '0;
      end else if (w_sending && !w_rdy && !w_last && (r_wait != '1)) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_accept && w_route_a) begin
        r_a_addr  <= in_addr;
        r_a_wdata <= in_wdata;
        r_a_we    <= in_we;
      end
      if (w_accept && w_is_b) begin
        r_b_addr  <= in_addr;
        r_b_wdata <= in_wdata;
        r_b_we    <= in_we;
      end
    end
  end

  assign a_addr      = r_a_addr;
  assign a_wdata     = r_a_wdata;
  assign a_we        = r_a_we;
  assign b_addr      = r_b_addr;
  assign b_wdata     = r_b_wdata;
  assign b_we        = r_b_we;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_store_data_demux.sv
// Scoreboard bench for store_data_demux: driver pushes expected outcomes, monitor checks at negedge.
module tb_store_data_demux;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic        in_we = 1'b0;
  logic        a_valid, a_ready = 1'b0, a_we;
  logic [31:0] a_addr, a_wdata;
  logic        b_valid, b_ready = 1'b0, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        busy, timeout_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          port;   // 0 = A, 1 = B, 2 = none
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          cycles; // cycles valid is expected high
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int   run = 0;

  store_data_demux #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata), .in_we(in_we),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference routing taken straight from the address map rules.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wd, input logic we, input int d);
    exp_t e;
    e.addr = addr; e.wdata = wd; e.we = we; e.tmo = 1'b0;
    if (addr < 32'h3000)                             e.port = 0;
    else if (addr >= 32'h7F00 && addr <= 32'h7F1F)   e.port = 1;
    else begin
`ifdef DEMUX_UNMAPPED_ERR_EN
      e.port = 2;
`else
      e.port = 0;
`endif
    end
    if (e.port == 2)           begin e.cycles = 0; e.tmo = 1'b1; end
    else if (d <= TIMEOUT - 1) e.cycles = d + 1;
    else                       begin e.cycles = TIMEOUT; e.tmo = 1'b1; end
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      run = 0;
    end else begin
      check("ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
      if (a_valid || b_valid) begin
        run++;
        check("exclusive", {31'd0, a_valid && b_valid}, 32'd0);
        if (q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else if (a_valid) begin
          check("port_is_A", q[0].port, 0);
          check("a_addr", a_addr, q[0].addr);
          check("a_wdata", a_wdata, q[0].wdata);
          check("a_we", {31'd0, a_we}, {31'd0, q[0].we});
        end else begin
          check("port_is_B", q[0].port, 1);
          check("b_addr", b_addr, q[0].addr);
          check("b_wdata", b_wdata, q[0].wdata);
          check("b_we", {31'd0, b_we}, {31'd0, q[0].we});
        end
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
          if (q.size() != 0) begin
            check("hs_not_timeout", {31'd0, q[0].tmo}, 32'd0);
            check("hs_cycles", run, q[0].cycles);
            void'(q.pop_front());
          end
          run = 0;
        end
      end
      if (timeout_err) begin
        if (q.size() == 0) begin
          check("unexpected_timeout", 32'd1, 32'd0);
        end else begin
          check("timeout_expected", {31'd0, q[0].tmo}, 32'd1);
          check("timeout_cycles", run, q[0].cycles);
          void'(q.pop_front());
        end
        run = 0;
      end
    end
  end

  // Driver: one request, target ready rises after d cycles; other port's ready is noise.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic we, input int d);
    exp_t e;
    int   k;
    e = model(addr, wd, we, d);
    q.push_back(e);
    in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_we = we;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!in_ready) begin
      a_ready = (e.port == 0) ? (k >= d) : 1'($urandom_range(0, 1));
      b_ready = (e.port == 1) ? (k >= d) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
      if (k > 300) begin
        check("req_bound", 32'd1, 32'd0);
        break;
      end
    end
    a_ready = 1'($urandom_range(0, 1));
    b_ready = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] dir_addr [9] = '{32'h10, 32'h2FFC, 32'h3000, 32'h7F1F, 32'h7F20,
                                32'h7F00, 32'h7F04, 32'h40, 32'hFFFF_FFFF};

  initial begin
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_a_addr", a_addr, 32'd0);
    check("rst_b_wdata", b_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    do_req(32'h10, 32'hDEADBEEF, 1'b1, 0);
    do_req(32'h7F04, 32'h1234_5678, 1'b0, 5);
    do_req(32'h40, 32'hA5A5_A5A5, 1'b1, 100);
    do_req(32'h40, 32'h5A5A_5A5A, 1'b1, TIMEOUT - 1);
    do_req(32'h40, 32'h0F0F_0F0F, 1'b0, TIMEOUT);
    foreach (dir_addr[i]) do_req(dir_addr[i], $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Asynchronous reset mid-request drops it immediately.
    q.push_back(model(32'h100, 32'h1, 1'b1, 100));
    in_valid = 1'b1; in_addr = 32'h100; in_wdata = 32'h1; in_we = 1'b1; a_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_a_valid", {31'd0, a_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_a_addr", a_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ad;
      case ($urandom_range(0, 3))
        0: ad = $urandom_range(0, 32'h2FFF);
        1: ad = 32'h7F00 + $urandom_range(0, 31);
        2: ad = $urandom;
        default: ad = 32'h7EF0 + $urandom_range(0, 63);
      endcase
      do_req(ad, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, TIMEOUT + 2));
    end

    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_data_demux.md
Name: store_data_demux

Overview:
- Routes one CPU store/load request stream to one of two slave ports: port A (data memory) or port B (peripheral bridge), selected by address.
- Sits between the MEM-stage request path and the slaves. The complementary block to the 2:1 read-data select.
- Registers each accepted request, holds it under a valid/ready handshake and tracks a per-request wait counter.

Parameters:
- A_LIMIT, 32'h0000_3000: addresses below this go to port A.
- B_BASE, 32'h0000_7F00: lowest port-B address.
- B_TOP, 32'h0000_7F1F: highest port-B address (inclusive).
- TIMEOUT, 16: maximum cycles a request waits for ready. Range 2..255.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: request present.
- in_ready, out, 1: block can accept a request.
- in_addr, in, 32: byte address.
- in_wdata, in, 32: store data.
- in_we, in, 1: 1 = write, 0 = read.
- a_valid, out, 1: request valid on port A.
- a_ready, in, 1: port A accepts.
- a_addr / a_wdata, out, 32 each: port A request address and data.
- a_we, out, 1: port A write enable.
- b_valid, out, 1: request valid on port B.
- b_ready, in, 1: port B accepts.
- b_addr / b_wdata, out, 32 each: port B request address and data.
- b_we, out, 1: port B write enable.
- busy, out, 1: request in flight; feeds the stall logic.
- timeout_err, out, 1: one-cycle pulse when a request is abandoned.

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - State goes to IDLE.
  - a_valid, b_valid, busy and timeout_err go to 0; in_ready goes to 1.
  - All addr/wdata/we registers go to 0 and the wait counter goes to 0.
  - An in-flight request is dropped silently.
- States: IDLE, SEND_A, SEND_B.
- in_ready = (state == IDLE). busy = !in_ready.
- IDLE, on in_valid=1 (the accept edge):
  - Capture addr, wdata and we into the output registers; clear the wait counter.
  - If in_addr < A_LIMIT, go to SEND_A.
  - Else if B_BASE <= in_addr <= B_TOP, go to SEND_B.
  - Else the address is unmapped; handling is given under Optional Feature.
  - Comparisons are unsigned, 32-bit.
- Latency: a request accepted at edge N drives x_valid=1 from edge N to the edge after N.
- SEND_x:
  - x_valid = 1. The other port's valid = 0.
  - Output payload is held stable until the handshake completes.
- Handshake:
  - Completes at an edge where x_valid and x_ready are both 1; the state returns to IDLE.
  - No back-to-back acceptance: the earliest new accept is the following edge, so throughput is at most 1 request per 2 cycles.
- Wait counter:
  - Increments (saturating, 8-bit) each SEND_x cycle without x_ready.
  - If it reaches TIMEOUT-1 with x_ready still 0, the next edge does three things: it abandons the request, returns the state to IDLE and pulses timeout_err for exactly 1 cycle.
  - If x_ready=1 arrives in the same cycle as the limit, the handshake wins and there is no error.
- Port exclusivity: a_valid and b_valid are never both 1.
- Ready signals arriving while the block is in IDLE are ignored.
- Unused output port: payload holds its last value; only valid is meaningful.

Optional Feature:
- Macro: DEMUX_UNMAPPED_ERR_EN.
- Defined: an unmapped address is accepted (in_ready=1 handshake), no port is asserted, the state stays IDLE and timeout_err pulses for 1 cycle on the following cycle.
- Undefined: an unmapped address routes to port A (SEND_A) as if it were below A_LIMIT, and the error path exists only for timeouts.

Test Plan:
- Reset mid-request: accept addr 0x100 while a_ready is held 0, then assert reset=0 asynchronously mid-cycle → a_valid drops immediately, in_ready=1. After release, a new request is accepted normally.
- Port A write: in_valid=1, addr=0x0000_0010, wdata=0xDEADBEEF, we=1, a_ready=1 → a_valid=1 for exactly 1 cycle with a_addr=0x10, a_wdata=0xDEADBEEF, a_we=1; b_valid stays 0; in_ready is back to 1 after 2 cycles.
- Port B read with backpressure: addr=0x0000_7F04, we=0, b_ready low for 5 cycles then high → b_valid=1 for 6 cycles with payload stable; busy=1 throughout; no timeout_err.
- Boundaries: addr=0x2FFC → A. addr=0x3000 (undefined macro) → A. addr=0x7F1F → B. addr=0x7F20 → A without the macro; with DEMUX_UNMAPPED_ERR_EN → no valid asserted and a timeout_err pulse.
- Timeout: TIMEOUT=16, addr=0x40, a_ready held 0 → a_valid high for 16 cycles, then timeout_err=1 for 1 cycle and in_ready=1. A repeat run with a_ready=1 on the 16th cycle → clean handshake, no error.
- Stream: 4 requests alternating A/B/A/B, in_valid held 1, both readies 1 → 4 completions in 8 cycles, in order, valids never overlapping.
